tt_capture_sweep: RTL and testbench
===================================

Name: tt_capture_sweep

Overview:
- Sequential counterpart to the 7-input majority-network function blocks: it reads a function back out as its truth table.
- Drives all 128 input vectors onto an external 7-input combinational function under test (FUT) and samples the FUT output for each vector.
- Assembles the 128-bit truth-table signature (hex order, MSB first) and streams it as four 32-bit words over a valid/ready interface.
- Reports the onset popcount. Used by the classification bench to regenerate and verify per-function signatures.

Parameters:
- SETTLE, 1, idle cycles after each new stimulus before sampling f_in (range 0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin sweep; honoured only in IDLE.
- x  output  7  registered stimulus to FUT; x[0]=x0 … x[6]=x6.
- f_in  input  1  FUT output, combinational from x.
- busy  output  1  high from the cycle after an accepted start until done.
- tt_valid  output  1  truth-table word valid.
- tt_ready  input  1  consumer ready.
- tt_data  output  32  truth-table word.
- tt_index  output  2  word number, 3 down to 0.
- tt_last  output  1  high with word 0.
- done  output  1  one-cycle pulse after the last word is accepted.
- ones_count  output  8  number of minterms with f=1 (0..128).

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE. x=0, busy=0, tt_valid=0, tt_data=0, tt_index=3, tt_last=0, done=0, ones_count=0.
  - Internal 128-bit table and counters are cleared.
  - Reset mid-sweep or mid-emit abandons the operation; no partial words are emitted after release.
- Bit convention: truth-table bit i = f(x=i), with x0 as the LSB of i.
  - Word k carries bits 32k+31..32k.
  - Words are emitted 3,2,1,0, so the concatenation equals the hex signature MSB-first.
- IDLE:
  - x=0.
  - When start=1, load idx=0, wait counter=SETTLE, ones_count=0, and enter SWEEP.
- SWEEP:
  - x=idx.
  - While the wait counter is non-zero, decrement it.
  - When the counter is 0, sample f_in into table[idx] and add it to ones_count.
    - If idx=127, go to EMIT.
    - Otherwise idx++ and reload the counter to SETTLE.
  - Each vector takes exactly SETTLE+1 cycles; a full sweep takes 128*(SETTLE+1) cycles.
- EMIT:
  - tt_valid=1, tt_data=word[w], tt_index=w, tt_last=(w==0). w starts at 3.
  - A transfer occurs when tt_valid&tt_ready. On transfer, w decrements.
  - After word 0 transfers, tt_valid drops and the block goes to DONE.
  - While tt_ready=0, data, index and valid are held stable; x holds 127.
- DONE:
  - done=1 for one cycle, busy drops, then IDLE.
  - ones_count holds until the next accepted start.
- busy is 1 in SWEEP and EMIT.
- start while busy or in DONE is ignored; it is not queued.
- start asserted in the same cycle that DONE returns to IDLE is not accepted; it must be high in IDLE.
- ones_count is 8 bits and does not saturate; the value 128 fits.

Test Plan:
- FUT f=x0, SETTLE=1, tt_ready=1:
  - words 0xAAAAAAAA ×4, indices 3,2,1,0, tt_last only on 0, ones_count=64.
  - done pulses 256+4+1 cycles (±1 per pipeline convention, fixed once by RTL) after start; the bench checks the exact count is constant across runs.
- FUT f=x6:
  - word3=word2=0xFFFFFFFF, word1=word0=0x00000000, ones_count=64.
- FUT f=AND(x0..x6), SETTLE=0:
  - word3=0x80000000, others 0, ones_count=1.
  - Sweep takes 128 cycles.
- FUT f=1 with tt_ready toggling 1 cycle on / 3 off:
  - all words 0xFFFFFFFF, ones_count=128.
  - tt_data and tt_index are stable while stalled; no word is duplicated or skipped.
- start pulsed again mid-sweep and mid-emit:
  - ignored, and the output matches an undisturbed run.
- rst_n low at vector 50:
  - all outputs return to reset values immediately.
  - A subsequent start with FUT f=x0 yields 0xAAAAAAAA ×4.

Source files
------------

// File: rtl/tt_capture_sweep.sv
// Sweeps all 128 input vectors of an external 7-input function, captures its truth
// table and streams it out as four 32-bit words (word 3 first), with an onset count.
module tt_capture_sweep #(
   parameter int unsigned SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [6:0]  x,
   input  logic        f_in,
   output logic        busy,
   output logic        tt_valid,
   input  logic        tt_ready,
   output logic [31:0] tt_data,
   output logic [1:0]  tt_index,
   output logic        tt_last,
   output logic        done,
   output logic [7:0]  ones_count,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_EMIT, S_DONE} state_t;

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   // Handshake: a word moves on any rising edge where tt_valid && tt_ready; while
   // tt_ready is low, tt_valid, tt_data and tt_index are held unchanged.

   state_t         state_q, state_d;
   logic [6:0]     idx_q, idx_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [127:0]   table_q, table_d;
   logic [7:0]     ones_q, ones_d;
   logic [1:0]     w_q, w_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 7'd0;
         cnt_q   <= 4'd0;
         table_q <= 128'd0;
         ones_q  <= 8'd0;
         w_q     <= 2'd3;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         table_q <= table_d;
         ones_q  <= ones_d;
         w_q     <= w_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      table_d = table_q;
      ones_d  = ones_q;
      w_d     = w_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = 7'd0;
               cnt_d   = SETTLE_C;
               ones_d  = 8'd0;
               state_d = S_SWEEP;
            end
         end
         S_SWEEP: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               table_d[idx_q] = f_in;
               ones_d         = ones_q + {7'd0, f_in};
               if (idx_q == 7'd127) begin
                  w_d     = 2'd3;
                  state_d = S_EMIT;
               end else begin
                  idx_d = idx_q + 7'd1;
                  cnt_d = SETTLE_C;
               end
            end
         end
         S_EMIT: begin
            if (tt_ready) begin
               if (w_q == 2'd0) state_d = S_DONE;
               else             w_d     = w_q - 2'd1;
            end
         end
         S_DONE: begin
            // x returns to 0 and the word pointer rearms for the next sweep
            idx_d   = 7'd0;
            w_d     = 2'd3;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign x           = idx_q;
   assign busy        = (state_q == S_SWEEP) || (state_q == S_EMIT);
   assign tt_valid    = (state_q == S_EMIT);
   assign tt_data     = tt_valid ? table_q[{w_q, 5'd0} +: 32] : 32'd0;
   assign tt_index    = w_q;
   assign tt_last     = tt_valid && (w_q == 2'd0);
   assign done        = (state_q == S_DONE);
   assign ones_count  = ones_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tt_capture_sweep.sv
// Bench for tt_capture_sweep: two instances (SETTLE=1 and SETTLE=0) read back
// directed and random functions; results are compared against a table-level model.
module tb_tt_capture_sweep;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start1 = 1'b0, start0 = 1'b0;
   logic        tt_ready = 1'b0;
   logic [6:0]  x1, x0;
   logic        f1, f0;
   logic        busy1, busy0, valid1, valid0, last1, last0, done1, done0;
   logic [31:0] data1, data0;
   logic [1:0]  index1, index0, st1, st0;
   logic [7:0]  ones1, ones0;

   int          sel = 0;
   int          ready_mode = 0;
   logic [127:0] rand_tt = 128'd0;
   int          total = 0, bad = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic fut(input int s, input logic [127:0] rt, input logic [6:0] v);
      case (s)
         0: return v[0];
         1: return v[6];
         2: return &v;
         3: return 1'b1;
         default: return rt[v];
      endcase
   endfunction

   assign f1 = fut(sel, rand_tt, x1);
   assign f0 = fut(sel, rand_tt, x0);

   tt_capture_sweep #(.SETTLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .x(x1), .f_in(f1), .busy(busy1),
      .tt_valid(valid1), .tt_ready(tt_ready), .tt_data(data1), .tt_index(index1),
      .tt_last(last1), .done(done1), .ones_count(ones1), .dbg_state_o(st1));

   tt_capture_sweep #(.SETTLE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .x(x0), .f_in(f0), .busy(busy0),
      .tt_valid(valid0), .tt_ready(tt_ready), .tt_data(data0), .tt_index(index0),
      .tt_last(last0), .done(done0), .ones_count(ones0), .dbg_state_o(st0));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // ready pattern: 0 = always ready, 1 = one cycle on / three off, 2 = random
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       tt_ready = 1'b1;
         1:       tt_ready = (cyc % 4 == 0);
         default: tt_ready = 1'($urandom_range(0, 1));
      endcase
   end

   logic [31:0] got_d1[$], got_d0[$];
   logic [1:0]  got_i1[$], got_i0[$];
   logic        got_l1[$], got_l0[$];
   int          done_n1 = 0, done_n0 = 0, done_cyc1 = 0, done_cyc0 = 0;
   logic        hold1 = 1'b0, hold0 = 1'b0;
   logic [31:0] hd1, hd0;
   logic [1:0]  hi1, hi0;

   // Inputs only change near the rising edge, so what is seen here is what the next edge sees.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold1 = 1'b0;
         hold0 = 1'b0;
      end else begin
         if (hold1) begin
            check("stall_valid1", valid1, 1);
            check("stall_data1", data1, hd1);
            check("stall_index1", index1, hi1);
            hold1 = 1'b0;
         end
         if (valid1 && tt_ready) begin
            got_d1.push_back(data1); got_i1.push_back(index1); got_l1.push_back(last1);
         end else if (valid1) begin
            hold1 = 1'b1; hd1 = data1; hi1 = index1;
         end
         if (done1) begin done_n1++; done_cyc1 = cyc; end
         if (hold0) begin
            check("stall_valid0", valid0, 1);
            check("stall_data0", data0, hd0);
            check("stall_index0", index0, hi0);
            hold0 = 1'b0;
         end
         if (valid0 && tt_ready) begin
            got_d0.push_back(data0); got_i0.push_back(index0); got_l0.push_back(last0);
         end else if (valid0) begin
            hold0 = 1'b1; hd0 = data0; hi0 = index0;
         end
         if (done0) begin done_n0++; done_cyc0 = cyc; end
      end
   end

   task automatic clear_mon();
      got_d1.delete(); got_i1.delete(); got_l1.delete();
      got_d0.delete(); got_i0.delete(); got_l0.delete();
      done_n1 = 0; done_n0 = 0;
   endtask

   task automatic chk_rst(input string tag, input logic [6:0] xx, input logic b, input logic v,
                          input logic [31:0] d, input logic [1:0] i, input logic l,
                          input logic dn, input logic [7:0] oc);
      check({tag, "_x"}, xx, 0);
      check({tag, "_busy"}, b, 0);
      check({tag, "_valid"}, v, 0);
      check({tag, "_data"}, d, 0);
      check({tag, "_index"}, i, 3);
      check({tag, "_last"}, l, 0);
      check({tag, "_done"}, dn, 0);
      check({tag, "_ones"}, oc, 0);
   endtask

   task automatic chk_words(input string tag, input logic [31:0] exp_q[$], input logic [31:0] gd[$],
                            input logic [1:0] gi[$], input logic gl[$]);
      check({tag, "_nwords"}, gd.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < gd.size()) begin
            check($sformatf("%s_word%0d", tag, 3 - k), gd[k], exp_q[k]);
            check($sformatf("%s_index%0d", tag, 3 - k), gi[k], 3 - k);
            check($sformatf("%s_last%0d", tag, 3 - k), gl[k], (k == 3));
         end
      end
   endtask

   task automatic run(input string tag, input int s, input int rm, input bit disturb, input bit chk_lat);
      logic [127:0] tt;
      logic [31:0]  exp_q[$];
      int           ones = 0;
      int           st;
      int           lim;
      for (int i = 0; i < 128; i++) begin
         tt[i] = fut(s, rand_tt, 7'(i));
         ones += int'(tt[i]);
      end
      for (int k = 3; k >= 0; k--) exp_q.push_back(tt[32*k +: 32]);
      sel = s;
      ready_mode = rm;
      clear_mon();
      @(negedge clk);
      st = cyc;
      start1 = 1'b1; start0 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start0 = 1'b0;
      check({tag, "_busy1_start"}, busy1, 1);
      check({tag, "_busy0_start"}, busy0, 1);
      if (disturb) begin
         repeat (40) @(negedge clk);
         start1 = 1'b1; start0 = 1'b1;
         @(negedge clk);
         start1 = 1'b0; start0 = 1'b0;
         lim = 0;
         while (!valid1 && lim < 2000) begin @(negedge clk); lim++; end
         check({tag, "_emit_wait"}, lim < 2000, 1);
         start1 = 1'b1;
         @(negedge clk);
         start1 = 1'b0;
      end
      lim = 0;
      while ((done_n1 == 0 || done_n0 == 0) && lim < 3000) begin @(negedge clk); lim++; end
      check({tag, "_done_timeout"}, lim < 3000, 1);
      repeat (4) @(negedge clk);
      chk_words({tag, "_u1"}, exp_q, got_d1, got_i1, got_l1);
      chk_words({tag, "_u0"}, exp_q, got_d0, got_i0, got_l0);
      check({tag, "_ones1"}, ones1, ones);
      check({tag, "_ones0"}, ones0, ones);
      check({tag, "_done_n1"}, done_n1, 1);
      check({tag, "_done_n0"}, done_n0, 1);
      check({tag, "_idle_busy1"}, busy1, 0);
      check({tag, "_idle_valid0"}, valid0, 0);
      if (chk_lat) begin
         check({tag, "_lat1"}, done_cyc1 - st - 1, 128 * 2 + 4);
         check({tag, "_lat0"}, done_cyc0 - st - 1, 128 + 4);
      end
   endtask

   initial begin
      int lim;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_rst("rst_u1", x1, busy1, valid1, data1, index1, last1, done1, ones1);
      chk_rst("rst_u0", x0, busy0, valid0, data0, index0, last0, done0, ones0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run("f_x0", 0, 0, 0, 1);
      run("f_x0_again", 0, 0, 0, 1);
      run("f_x6", 1, 0, 0, 1);
      run("f_and", 2, 0, 0, 1);
      run("f_one_stall", 3, 1, 0, 0);
      rand_tt = {$urandom, $urandom, $urandom, $urandom};
      run("f_rand", 4, 2, 0, 1'b0);
      run("f_x0_disturb", 0, 1, 1, 0);
      rand_tt = {$urandom, $urandom, $urandom, $urandom};
      run("f_rand_disturb", 4, 2, 1, 0);

      sel = 0;
      ready_mode = 0;
      clear_mon();
      @(negedge clk);
      start1 = 1'b1; start0 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start0 = 1'b0;
      lim = 0;
      while (x1 != 7'd50 && lim < 1000) begin @(negedge clk); lim++; end
      check("midrst_wait", lim < 1000, 1);
      rst_n = 1'b0;
      #1;
      chk_rst("midrst_u1", x1, busy1, valid1, data1, index1, last1, done1, ones1);
      chk_rst("midrst_u0", x0, busy0, valid0, data0, index0, last0, done0, ones0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      check("midrst_words1", got_d1.size(), 0);
      check("midrst_words0", got_d0.size(), 0);
      check("midrst_done1", done_n1, 0);
      check("midrst_busy1", busy1, 0);
      run("f_x0_after_rst", 0, 0, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
